// File: rtl/game_pkg.sv
// game_pkg: types and constants shared by the gameplay blocks
// sitting in the VGA chain (motion control, level sequencing).
package game_pkg;

   localparam int LEVEL_W = 2;
   localparam int RGB_W   = 12;

   localparam logic [3:0] FADE_MAX = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      FADE_OUT,
      SWAP,
      FADE_IN
   } lvl_tr_state_t;

   // brightness scale of one 4-bit channel: top nibble of c*f
   function automatic logic [3:0] scale_chan(
      input logic [3:0] c,
      input logic [3:0] f
   );
      logic [7:0] p;
      p = {4'd0, c} * {4'd0, f};
      return p[7:4];
   endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: one stage of the VGA pipeline, timing plus 12-bit rgb.
interface vga_if;

   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in (
      input vcount,
      input hcount,
      input hsync,
      input vsync,
      input hblnk,
      input vblnk,
      input rgb
   );

   modport out (
      output vcount,
      output hcount,
      output hsync,
      output vsync,
      output hblnk,
      output vblnk,
      output rgb
   );

endinterface

// File: rtl/level_transition_ctl_rgb_fade.sv
// rgb_fade: registered per-channel brightness scaler, one cycle
// of latency, exact pass-through at full brightness.
module rgb_fade
   import game_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RGB_W-1:0] rgb,
   input  logic [3:0]       fade,
   output logic [RGB_W-1:0] faded
);

   logic [RGB_W-1:0] scaled;

   // c*15>>4 loses one step, so full brightness bypasses the multiply
   always_comb begin
      scaled = rgb;
      if (fade != FADE_MAX) begin
         scaled = {
            scale_chan(rgb[11:8], fade),
            scale_chan(rgb[7:4], fade),
            scale_chan(rgb[3:0], fade)
         };
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         faded <= '0;
      end else begin
         faded <= scaled;
      end
   end

endmodule

// File: rtl/level_transition_ctl.sv
// level_transition_ctl: on a level change freezes play, fades to
// black per frame, swaps the background bank, then fades back in.
module level_transition_ctl
   import game_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 2,
   parameter int HOLD_FRAMES     = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEVEL_W-1:0] level_in,
   output logic [LEVEL_W-1:0] bg_level,
   output logic               freeze,
   output logic               busy,
   output logic [3:0]         fade,
   vga_if.in                  vga_in,
   vga_if.out                 vga_out
);

   localparam int CNT_MAX =
      (FRAMES_PER_STEP > HOLD_FRAMES) ? FRAMES_PER_STEP : HOLD_FRAMES;
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] STEP_END = CNT_W'(FRAMES_PER_STEP);
   localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_FRAMES);

   lvl_tr_state_t state;
   lvl_tr_state_t state_n;

   logic [LEVEL_W-1:0] target;
   logic [LEVEL_W-1:0] target_n;
   logic [LEVEL_W-1:0] bg_n;
   logic [3:0]         fade_n;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_n;
   logic [CNT_W-1:0]   cnt_inc;

   logic vblnk_prev;
   logic frame_tick;
   logic lvl_diff;
   logic step_end;
   logic hold_end;

   logic [RGB_W-1:0] faded;

   // prev resets high so a vblank already in progress is not a tick
   assign frame_tick = vga_in.vblnk & ~vblnk_prev;
   assign lvl_diff   = (level_in != bg_level);
   assign cnt_inc    = cnt + CNT_W'(1);
   assign step_end   = (cnt_inc == STEP_END);
   assign hold_end   = (cnt_inc == HOLD_END);

   assign busy   = (state != IDLE);
   assign freeze = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fade       <= FADE_MAX;
         bg_level   <= '0;
         target     <= '0;
         cnt        <= '0;
         vblnk_prev <= 1'b1;
      end else begin
         state      <= state_n;
         fade       <= fade_n;
         bg_level   <= bg_n;
         target     <= target_n;
         cnt        <= cnt_n;
         vblnk_prev <= vga_in.vblnk;
      end
   end

   always_comb begin
      state_n  = state;
      fade_n   = fade;
      bg_n     = bg_level;
      target_n = target;
      cnt_n    = cnt;
      if (frame_tick) begin
         unique case (state)
            IDLE: begin
               if (lvl_diff) begin
                  target_n = level_in;
                  cnt_n    = '0;
                  state_n  = FADE_OUT;
               end
            end
            FADE_OUT: begin
               target_n = level_in;
               if (step_end) begin
                  cnt_n = '0;
                  if (fade == 4'd0) begin
                     state_n = SWAP;
                  end else begin
                     fade_n = fade - 4'd1;
                  end
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            SWAP: begin
               fade_n = 4'd0;
               if (cnt == '0) begin
                  bg_n = target;
               end
               if (hold_end) begin
                  cnt_n   = '0;
                  state_n = FADE_IN;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            FADE_IN: begin
               // a new level beats a coinciding step expiry
               if (lvl_diff) begin
                  target_n = level_in;
                  cnt_n    = '0;
                  state_n  = FADE_OUT;
               end else if (step_end) begin
                  cnt_n  = '0;
                  fade_n = fade + 4'd1;
                  if (fade == FADE_MAX - 4'd1) begin
                     state_n = IDLE;
                  end
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_out.vcount <= '0;
         vga_out.hcount <= '0;
         vga_out.hsync  <= 1'b0;
         vga_out.vsync  <= 1'b0;
         vga_out.hblnk  <= 1'b0;
         vga_out.vblnk  <= 1'b0;
      end else begin
         vga_out.vcount <= vga_in.vcount;
         vga_out.hcount <= vga_in.hcount;
         vga_out.hsync  <= vga_in.hsync;
         vga_out.vsync  <= vga_in.vsync;
         vga_out.hblnk  <= vga_in.hblnk;
         vga_out.vblnk  <= vga_in.vblnk;
      end
   end

   rgb_fade u_rgb_fade (
      .clk   (clk),
      .rst_n (rst_n),
      .rgb   (vga_in.rgb),
      .fade  (fade),
      .faded (faded)
   );

   assign vga_out.rgb = faded;

endmodule

// File: doc/level_transition_ctl.md
# level_transition_ctl

Sequencer for level changes. It watches the level index produced by the character motion controller and, on a change, freezes gameplay. It then fades the picture to black over whole frames, switches the background bank while the screen is black, and fades back in. It sits in the VGA chain directly after the character draw stage and owns the `bg_level` select consumed by the background ROM stage.

## Interface
- `FRAMES_PER_STEP`, default 2: frames spent at each fade value (≥1).
- `HOLD_FRAMES`, default 4: frames held fully black in SWAP (≥1).
- `clk`  in  1: pixel/system clock; the only clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `level_in`  in  2: current level index from the motion controller.
- `bg_level`  out  2: level index the background renderer must draw.
- `freeze`  out  1: high = motion controller must hold position and state.
- `busy`  out  1: high whenever not in IDLE.
- `fade`  out  4: current brightness; 15 = full, 0 = black.
- `vga_in`  in  `vga_if.in`: timing and rgb from the previous stage.
- `vga_out`  out  `vga_if.out`: registered timing and faded rgb.

## Operation
- **Frame tick:** 1-cycle pulse `frame_tick` on the rising edge of `vga_in.vblnk`. The previous-vblnk flop resets to 1, so no tick occurs on the first cycle after reset.
- **Level sampling:** `level_in` is sampled only on `frame_tick`. `target` is a 2-bit register that holds the latest sampled level.
- **States (enum in package):** IDLE, FADE_OUT, SWAP, FADE_IN.
- **IDLE:** `fade`=15, `freeze`=0. On `frame_tick` with `level_in != bg_level`: `target <= level_in`, frame counter cleared, go to FADE_OUT.
- **FADE_OUT:**
  - On each `frame_tick`, update `target` and increment the frame counter.
  - When the counter reaches `FRAMES_PER_STEP`: clear the counter and decrement `fade`.
  - When `fade` would go below 0, go instead to SWAP with the counter cleared.
- **SWAP:**
  - `fade`=0.
  - On the first `frame_tick`: `bg_level <= target`.
  - After `HOLD_FRAMES` ticks, go to FADE_IN.
  - `target` is not resampled in SWAP.
- **FADE_IN:**
  - Mirror of FADE_OUT: `fade` increments every `FRAMES_PER_STEP` ticks.
  - When `fade` = 15 and the step expires, go to IDLE.
  - If a `frame_tick` sees `level_in != bg_level`: `target <= level_in`, go to FADE_OUT. `fade` continues from its current value; it does not jump.
- **Levels equal again:** if `level_in` returns to `bg_level` during FADE_OUT, the sequence still completes. SWAP rewrites the same bank, and the fade in restores brightness.
- **Outputs:** `freeze` = `busy` = (state != IDLE), decoded from registered state.
- **RGB scaling, per 4-bit channel `c`:**
  - `fade`=15: output = `c` exactly (pass-through).
  - Otherwise: output = `(c*fade) >> 4`. The product is 8 bits; take bits [7:4].
- **Timing fields:** `vcount`, `hcount`, `hsync`, `vsync`, `hblnk`, `vblnk` pass through unmodified.

## Timing
- **Reset (asynchronous, `rst_n`=0):**
  - state IDLE, `bg_level`=0, `target`=0, `fade`=15, `freeze`=0, `busy`=0, counters 0.
  - All `vga_out` fields 0.
- **Reset release:** takes effect on the next `clk` edge. A reset mid-transition returns immediately to full brightness, level 0 bank, unfrozen.
- **VGA latency:** 1 `clk` for all `vga_out` fields. The `fade` value used is the registered value in the same cycle as `vga_in`.
- **Update alignment:**
  - State, `fade` and `bg_level` update only on the cycle after `frame_tick`, so mid-frame brightness never changes.
  - `freeze` rises 1 cycle after the triggering `frame_tick`.
- **Full transition length:** 16·`FRAMES_PER_STEP` (FADE_OUT) + `HOLD_FRAMES` + 15·`FRAMES_PER_STEP` (FADE_IN) frames. Defaults give 32 + 4 + 30 = 66 frames.
- **Simultaneous events:**
  - A `frame_tick` coinciding with a step expiry and a level change in FADE_IN: the level change wins, go to FADE_OUT, and `fade` is not incremented.
  - `frame_tick` while `rst_n` is low is ignored.

## Structure
- **Package (`vga_pkg` or a new `game_pkg`):**
  - `lvl_tr_state_t` enum.
  - `FADE_MAX = 4'd15`.
  - `LEVEL_W = 2`, shared with the motion controller's level output.
- **Sub-module `rgb_fade`:** a registered 12-bit scaler taking `rgb` and `fade`, with 1-cycle latency. It carries the three per-channel multiplies; the controller stays a pure FSM plus counters.
- **Top-level wiring:** motion controller `level` feeds `level_in`; `freeze` gates the motion controller's state register.

## Test plan
1. **Reset:** `rst_n`=0 mid-frame with `level_in`=2 → all outputs at reset values. After release, the first `frame_tick` starts FADE_OUT toward `target`=2, and `freeze`=1 one cycle later.
2. **Full transition:** `level_in` 0→1 and held, defaults → `fade` steps 15,14,…,0 every 2 frames. `bg_level`=1 at the first SWAP tick; back to `fade`=15, IDLE, `freeze`=0 after 66 frames total.
3. **Re-trigger in FADE_IN:** `level_in` 1→2 during FADE_IN at `fade`=7 → FADE_OUT from 7. SWAP sets `bg_level`=2.
4. **Level change during FADE_OUT:** `level_in` 0→1, then →3 before SWAP → `bg_level` becomes 3, not 1.
5. **Pixel math:** `rgb`=12'hF84, `fade`=8 → `vga_out.rgb`=12'h742 one cycle later. At `fade`=15, output = 12'hF84. At `fade`=0, output = 12'h000. Timing fields always equal the inputs delayed by 1 cycle.
6. **No spurious start:** `level_in` toggles and returns to `bg_level` between two vblank edges → stays IDLE, `freeze` never asserted.
